// File: rtl/img_pkg.sv
// Shared constants and types for the image-difference statistics stage.
package img_pkg;

  localparam int PIX_W = 4;
  localparam int N_PIX = 9;
  localparam int SAD_W = 8;
  localparam int IDX_W = 4;

  // Frames whose SAD falls strictly below this value count as a match.
  localparam logic [SAD_W-1:0] THRESH = 8'd20;

  // Raster index of the last sample in a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  typedef enum logic {
    S_IDLE,
    S_ACC
  } stat_state_t;

endpackage

// File: rtl/img_diff_stat_if.sv
// Sample stream in, per-frame result word out.
// master: the side that sources samples and consumes results.
// slave:  the statistics stage itself.
interface img_diff_stat_if;
  import img_pkg::*;

  logic             in_valid;
  logic [PIX_W-1:0] in_diff;
  logic             out_valid;
  logic [SAD_W-1:0] out_sad;
  logic [PIX_W-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic             out_match;

  modport master (
    output in_valid, in_diff,
    input  out_valid, out_sad, out_max, out_idx, out_match
  );

  modport slave (
    input  in_valid, in_diff,
    output out_valid, out_sad, out_max, out_idx, out_match
  );

endinterface

// File: rtl/diff_abs.sv
// Magnitude of one difference sample.
// IMG_DIFF_SIGNED_EN defined: input is two's complement, 0x8 -> 8, 0xF -> 1.
// IMG_DIFF_SIGNED_EN undefined: input is already an unsigned magnitude.
module diff_abs
  import img_pkg::*;
(
  input  logic [PIX_W-1:0] diff,
  output logic [PIX_W-1:0] mag
);

`ifdef IMG_DIFF_SIGNED_EN
  // -8 has no positive 4-bit counterpart; negating 0x8 wraps back to 0x8,
  // which read as unsigned is exactly the magnitude 8.
  assign mag = diff[PIX_W-1] ? -diff : diff;
`else
  assign mag = diff;
`endif

endmodule

// File: rtl/img_diff_stat.sv
// Per-frame statistics over the 9-sample difference stream: SAD, peak
// magnitude with its raster index, and a threshold match flag. Results
// appear as a one-cycle registered strobe one cycle after the last sample.
// Build option: IMG_DIFF_SIGNED_EN selects signed interpretation of in_diff.
module img_diff_stat
  import img_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  img_diff_stat_if.slave  bus
);

  stat_state_t      state_q, state_d;
  logic [IDX_W-1:0] cnt_q,   cnt_d;
  logic [SAD_W-1:0] sad_q,   sad_d;
  logic [PIX_W-1:0] max_q,   max_d;
  logic [IDX_W-1:0] idx_q,   idx_d;

  logic [PIX_W-1:0] mag;
  logic [SAD_W-1:0] acc_sad;
  logic [PIX_W-1:0] acc_max;
  logic [IDX_W-1:0] acc_idx;
  logic             load;

  diff_abs u_abs (
    .diff (bus.in_diff),
    .mag  (mag)
  );

  // Running results including the current sample. In IDLE the sample is
  // index 0, so it seeds the max unconditionally (even a zero magnitude);
  // afterwards only a strictly larger value moves the max, keeping the
  // lowest index on ties.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_sad = SAD_W'(mag);
      acc_max = mag;
      acc_idx = '0;
    end else begin
      acc_sad = sad_q + SAD_W'(mag);
      if (mag > max_q) begin
        acc_max = mag;
        acc_idx = cnt_q;
      end else begin
        acc_max = max_q;
        acc_idx = idx_q;
      end
    end
  end

  // Next-state and accumulator update; a gap mid-frame or the 9th sample
  // both return to IDLE with cleared accumulators.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sad_d   = sad_q;
    max_d   = max_q;
    idx_d   = idx_q;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_ACC;
          cnt_d   = IDX_W'(1);
          sad_d   = acc_sad;
          max_d   = acc_max;
          idx_d   = acc_idx;
        end
      end
      S_ACC: begin
        if (!bus.in_valid || cnt_q == LAST_IDX) begin
          load    = bus.in_valid;
          state_d = S_IDLE;
          cnt_d   = '0;
          sad_d   = '0;
          max_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
          sad_d = acc_sad;
          max_d = acc_max;
          idx_d = acc_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and accumulator registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sad_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sad_q   <= sad_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  // Result registers: loaded only on frame completion and held until the
  // next one; the strobe lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sad   <= '0;
      bus.out_max   <= '0;
      bus.out_idx   <= '0;
      bus.out_match <= 1'b0;
    end else begin
      bus.out_valid <= load;
      if (load) begin
        bus.out_sad   <= acc_sad;
        bus.out_max   <= acc_max;
        bus.out_idx   <= acc_idx;
        bus.out_match <= (acc_sad < THRESH);
      end
    end
  end

endmodule

// File: tb/tb_img_diff_stat.sv
// Directed bench for img_diff_stat: table of complete frames plus
// hand-written sequences for abort, reset mid-frame, back-to-back and
// overlong bursts. Expected values follow IMG_DIFF_SIGNED_EN when defined.
module tb_img_diff_stat;
  import img_pkg::*;

  typedef struct {
    logic [35:0] smp;   // sample 0 in the top nibble, sample 8 in the bottom
    int          sad;
    int          mx;
    int          idx;
    int          match;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  img_diff_stat_if bus ();

  img_diff_stat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  int cyc     = 0;
  int last_pulse_cyc = -1;
  int prev_pulse_cyc = -1;

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled shortly after the edge and before the stimulus
  // process looks at the count on the falling edge.
  always @(posedge clk) begin
    #2;
    if (bus.out_valid === 1'b1) begin
      n_pulse++;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input int sad, input int mx,
                           input int idx, input int match);
    check({tag, " out_valid"}, int'(bus.out_valid), 1);
    check({tag, " out_sad"},   int'(bus.out_sad),   sad);
    check({tag, " out_max"},   int'(bus.out_max),   mx);
    check({tag, " out_idx"},   int'(bus.out_idx),   idx);
    check({tag, " out_match"}, int'(bus.out_match), match);
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_diff  = d;
  endtask

  function automatic vec_t mk(input logic [35:0] s, input int sad,
                              input int mx, input int idx, input int match);
    vec_t v;
    v.smp = s; v.sad = sad; v.mx = mx; v.idx = idx; v.match = match;
    return v;
  endfunction

  vec_t tbl [7];

  initial begin
    int p0;

    tbl[0] = mk(36'h000000000,   0,  0, 0, 1);  // all zeros
`ifdef IMG_DIFF_SIGNED_EN
    tbl[1] = mk(36'h1234567F8,  37,  8, 8, 0);  // mixed signs
    tbl[2] = mk(36'hFFFFFFFFF,   9,  1, 0, 1);  // all -1
`else
    tbl[1] = mk(36'h1234567F8,  51, 15, 7, 0);
    tbl[2] = mk(36'hFFFFFFFFF, 135, 15, 0, 0);  // SAD upper bound
`endif
    tbl[3] = mk(36'h333333333,  27,  3, 0, 0);  // ties keep index 0
    tbl[4] = mk(36'h222222223,  19,  3, 8, 1);  // one below threshold
    tbl[5] = mk(36'h222222224,  20,  4, 8, 0);  // exactly at threshold
    tbl[6] = mk(36'h010626000,  15,  6, 3, 1);  // tie at 6 keeps index 3

    bus.in_valid = 1'b0;
    bus.in_diff  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset out_sad",   int'(bus.out_sad),   0);
    check("reset out_max",   int'(bus.out_max),   0);
    check("reset out_idx",   int'(bus.out_idx),   0);
    check("reset out_match", int'(bus.out_match), 0);
    rst = 1'b0;
    @(negedge clk);

    // Complete frames from the table, separated by one idle cycle.
    for (int i = 0; i < 7; i++) begin
      p0 = n_pulse;
      for (int k = 0; k < 9; k++) drive(1'b1, tbl[i].smp[35-4*k -: 4]);
      drive(1'b0, 4'h0);
      check_res($sformatf("vec%0d", i), tbl[i].sad, tbl[i].mx, tbl[i].idx, tbl[i].match);
      @(negedge clk);
      check($sformatf("vec%0d strobe width", i), int'(bus.out_valid), 0);
      check($sformatf("vec%0d pulses", i), n_pulse - p0, 1);
    end

    // Abort: a one-cycle gap discards the partial frame.
    p0 = n_pulse;
    repeat (5) drive(1'b1, 4'h5);
    drive(1'b0, 4'h0);
    repeat (9) drive(1'b1, 4'h1);
    drive(1'b0, 4'h0);
    check_res("abort", 9, 1, 0, 1);
    check("abort pulses", n_pulse - p0, 1);

    // Reset mid-frame: rst arrives with sample 6; the remaining three
    // samples must not complete a frame.
    p0 = n_pulse;
    repeat (5) drive(1'b1, 4'h4);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_diff  = 4'h4;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst out_sad",   int'(bus.out_sad),   0);
    check("rst out_max",   int'(bus.out_max),   0);
    check("rst out_idx",   int'(bus.out_idx),   0);
    check("rst out_match", int'(bus.out_match), 0);
    repeat (3) drive(1'b1, 4'h4);
    drive(1'b0, 4'h0);
    drive(1'b0, 4'h0);
    check("rst pulses", n_pulse - p0, 0);
    repeat (9) drive(1'b1, 4'h2);
    drive(1'b0, 4'h0);
    check_res("post-rst", 18, 2, 0, 1);

    // Back-to-back: A = 9 x 1, B = 8 x 0 then 7, no gap between them.
    @(negedge clk);
    p0 = n_pulse;
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, (k < 9) ? 4'h1 : ((k == 17) ? 4'h7 : 4'h0));
      if (k == 9) check_res("b2b A", 9, 1, 0, 1);
      if (k > 9) begin
        check($sformatf("b2b hold valid k%0d", k), int'(bus.out_valid), 0);
        check($sformatf("b2b hold sad k%0d", k),   int'(bus.out_sad),   9);
      end
    end
    drive(1'b0, 4'h0);
    check_res("b2b B", 7, 7, 8, 1);
    check("b2b pulses", n_pulse - p0, 2);
    check("b2b spacing", last_pulse_cyc - prev_pulse_cyc, 9);

    // Overlong burst: the 10th sample becomes index 0 of the next frame.
    @(negedge clk);
    p0 = n_pulse;
    for (int k = 0; k < 18; k++)
      drive(1'b1, (k < 9) ? 4'h1 : ((k == 9) ? 4'h4 : 4'h0));
    drive(1'b0, 4'h0);
    check_res("overlong", 4, 4, 0, 1);
    check("overlong pulses", n_pulse - p0, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
